// File: rtl/branch_sched_pkg.sv
// branch_sched_pkg: shared types and helpers for the branch update scheduler
package branch_sched_pkg;
  localparam int MAX_DATA_WIDTH = 64;
  typedef enum logic [1:0] {IDLE, ISSUE, COOLDOWN} state_t;
  typedef struct packed {
    logic cond;
    logic taken;
    logic [MAX_DATA_WIDTH-1:0] pc;
    logic [MAX_DATA_WIDTH-1:0] target;
  } entry_t;
  function automatic int cool_w(input int tl);
    return (tl > 2) ? $clog2(tl) : 1;
  endfunction
endpackage

// File: rtl/branch_update_fifo.sv
// branch_update_fifo: synchronous FIFO of resolved-branch entries
module branch_update_fifo
  import branch_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  entry_t                   din,
  input  logic                     pop,
  output entry_t                   dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  entry_t mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign full    = count == DEPTH[AW:0];
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wptr] <= din;
      wptr  <= wptr + AW'(do_push);
      rptr  <= rptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/branch_update_scheduler.sv
// branch_update_scheduler: queues resolved branches and issues spaced predictor/BTB update pulses
module branch_update_scheduler
  import branch_sched_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int QUEUE_DEPTH   = 4,
  parameter int TRAIN_LATENCY = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_cond,
  input  logic                           in_taken,
  input  logic [DATA_WIDTH-1:0]          in_pc,
  input  logic [DATA_WIDTH-1:0]          in_target,
  output logic                           update_predictor,
  output logic                           update_btb,
  output logic                           actually_taken,
  output logic [DATA_WIDTH-1:0]          resolved_pc,
  output logic [DATA_WIDTH-1:0]          resolved_pc_target,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
  output logic                           idle
);
  localparam int CW = cool_w(TRAIN_LATENCY);
  entry_t head, din;
  logic full, empty, pop, push;
  state_t state_q, state_d;
  logic [CW-1:0] cool_q, cool_d;
  assign in_ready = !rst && !full;
  // Not-taken non-conditional records are consumed but need no update
  assign push = in_valid && in_ready && (in_cond || in_taken);
  assign din  = '{cond: in_cond, taken: in_taken,
                  pc: MAX_DATA_WIDTH'(in_pc), target: MAX_DATA_WIDTH'(in_target)};
  assign idle = empty && state_q == IDLE;
  branch_update_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din(din), .pop(pop),
    .dout(head), .full(full), .empty(empty), .count(queue_count)
  );
  always_comb begin
    pop     = 1'b0;
    state_d = state_q;
    cool_d  = cool_q;
    case (state_q)
      IDLE: begin
        pop     = !empty;
        state_d = empty ? IDLE : ISSUE;
      end
      ISSUE: begin
        if (TRAIN_LATENCY == 1) begin
          pop     = !empty;
          state_d = empty ? IDLE : ISSUE;
        end else begin
          cool_d  = CW'(TRAIN_LATENCY - 2);
          state_d = COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (cool_q != '0) cool_d = cool_q - CW'(1);
        else begin
          pop     = !empty;
          state_d = empty ? IDLE : ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= IDLE;
      cool_q             <= '0;
      update_predictor   <= 1'b0;
      update_btb         <= 1'b0;
      actually_taken     <= 1'b0;
      resolved_pc        <= '0;
      resolved_pc_target <= '0;
    end else begin
      state_q          <= state_d;
      cool_q           <= cool_d;
      update_predictor <= pop && head.cond;
      update_btb       <= pop && head.taken;
      if (pop) begin
        actually_taken     <= head.taken;
        resolved_pc        <= DATA_WIDTH'(head.pc);
        resolved_pc_target <= DATA_WIDTH'(head.target);
      end
    end
  end
endmodule

// File: tb/tb_branch_update_scheduler.sv
// tb_branch_update_scheduler: directed checks on three instances with TRAIN_LATENCY 1, 2 and 3
module tb_branch_update_scheduler;
  logic clk = 1'b0;
  logic rst;
  logic [2:0] v;
  logic c, t;
  logic [31:0] pc, tg;
  logic rdy [3], up [3], ub [3], at [3], idl [3];
  logic [31:0] rpc [3], rtg [3];
  logic [2:0] qc [3];
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    branch_update_scheduler #(.DATA_WIDTH(32), .QUEUE_DEPTH(4), .TRAIN_LATENCY(g + 1)) dut (
      .clk(clk), .rst(rst), .in_valid(v[g]), .in_ready(rdy[g]),
      .in_cond(c), .in_taken(t), .in_pc(pc), .in_target(tg),
      .update_predictor(up[g]), .update_btb(ub[g]), .actually_taken(at[g]),
      .resolved_pc(rpc[g]), .resolved_pc_target(rtg[g]),
      .queue_count(qc[g]), .idle(idl[g])
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; v = 3'b111; c = 1'b1; t = 1'b1; pc = 32'h10; tg = 32'h20;
    repeat (3) begin
      step();
      for (int k = 0; k < 3; k++) begin
        vecs++; if (rdy[k] !== 1'b0) begin errs++; $display("FAIL reset_ready[%0d]: got %b want 0", k, rdy[k]); end
        vecs++; if ({up[k], ub[k]} !== 2'b00) begin errs++; $display("FAIL reset_strobes[%0d]: got %b want 00", k, {up[k], ub[k]}); end
        vecs++; if (qc[k] !== 3'd0) begin errs++; $display("FAIL reset_count[%0d]: got %0d want 0", k, qc[k]); end
      end
    end
    rst = 1'b0; v = 3'b000;
    step();
    for (int k = 0; k < 3; k++) begin
      vecs++; if (idl[k] !== 1'b1) begin errs++; $display("FAIL post_reset_idle[%0d]: got %b want 1", k, idl[k]); end
      vecs++; if (rdy[k] !== 1'b1) begin errs++; $display("FAIL post_reset_ready[%0d]: got %b want 1", k, rdy[k]); end
      vecs++; if (rpc[k] !== 32'h0) begin errs++; $display("FAIL post_reset_pc[%0d]: got %0h want 0", k, rpc[k]); end
    end
  endtask

  task automatic test_single();
    c = 1'b1; t = 1'b1; pc = 32'h100; tg = 32'h140; v[1] = 1'b1;
    step();
    v[1] = 1'b0;
    vecs++; if ({up[1], ub[1]} !== 2'b00) begin errs++; $display("FAIL single_early: got %b want 00", {up[1], ub[1]}); end
    step();
    vecs++; if ({up[1], ub[1], at[1]} !== 3'b111) begin errs++; $display("FAIL single_strobes: got %b want 111", {up[1], ub[1], at[1]}); end
    vecs++; if (rpc[1] !== 32'h100) begin errs++; $display("FAIL single_pc: got %0h want 100", rpc[1]); end
    vecs++; if (rtg[1] !== 32'h140) begin errs++; $display("FAIL single_target: got %0h want 140", rtg[1]); end
    step();
    vecs++; if ({up[1], ub[1]} !== 2'b00) begin errs++; $display("FAIL single_width: got %b want 00", {up[1], ub[1]}); end
    vecs++; if (rpc[1] !== 32'h100) begin errs++; $display("FAIL single_hold: got %0h want 100", rpc[1]); end
    step();
    vecs++; if (idl[1] !== 1'b1) begin errs++; $display("FAIL single_idle: got %b want 1", idl[1]); end
  endtask

  task automatic test_filter();
    logic [31:0] pcs [3] = '{32'h200, 32'h300, 32'h400};
    logic cs [3] = '{1'b1, 1'b0, 1'b0};
    logic ts [3] = '{1'b0, 1'b1, 1'b0};
    int pi [4] = '{-1, -1, -1, -1};
    logic pu [4], pb [4];
    logic [31:0] pp [4];
    int n = 0;
    int mq = 0;
    for (int i = 0; i < 10; i++) begin
      v[1] = i < 3;
      if (i < 3) begin c = cs[i]; t = ts[i]; pc = pcs[i]; tg = pcs[i] + 32'h4; end
      step();
      if ((up[1] || ub[1]) && n < 4) begin pi[n] = i; pu[n] = up[1]; pb[n] = ub[1]; pp[n] = rpc[1]; n++; end
      if (int'(qc[1]) > mq) mq = int'(qc[1]);
    end
    v[1] = 1'b0;
    vecs++; if (n !== 2) begin errs++; $display("FAIL filter_pulses: got %0d want 2", n); end
    vecs++; if (pi[0] !== 1 || pi[1] !== 3) begin errs++; $display("FAIL filter_timing: got %0d,%0d want 1,3", pi[0], pi[1]); end
    vecs++; if ({pu[0], pb[0], pp[0]} !== {2'b10, 32'h200}) begin errs++; $display("FAIL filter_pred_only: got %b%b %0h want 10 200", pu[0], pb[0], pp[0]); end
    vecs++; if ({pu[1], pb[1], pp[1]} !== {2'b01, 32'h300}) begin errs++; $display("FAIL filter_btb_only: got %b%b %0h want 01 300", pu[1], pb[1], pp[1]); end
    vecs++; if (mq !== 1) begin errs++; $display("FAIL filter_max_count: got %0d want 1", mq); end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int n = 0;
    int pi [8];
    logic [31:0] pp [8];
    logic x;
    logic saw_full = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (sent < 6) begin
        v[2] = 1'b1; c = sent[0]; t = 1'b1; pc = 32'h1000 + 32'(sent * 16); tg = pc + 32'h40;
      end else v[2] = 1'b0;
      x = v[2] && rdy[2];
      step();
      if (x) sent++;
      if ((up[2] || ub[2]) && n < 8) begin pi[n] = i; pp[n] = rpc[2]; n++; end
      if (qc[2] == 3'd4) begin
        saw_full = 1'b1;
        vecs++; if (rdy[2] !== 1'b0) begin errs++; $display("FAIL bp_ready_when_full: got %b want 0", rdy[2]); end
      end
    end
    v[2] = 1'b0;
    vecs++; if (saw_full !== 1'b1) begin errs++; $display("FAIL bp_full_reached: got %b want 1", saw_full); end
    vecs++; if (sent !== 6) begin errs++; $display("FAIL bp_accepted: got %0d want 6", sent); end
    vecs++; if (n !== 6) begin errs++; $display("FAIL bp_pulses: got %0d want 6", n); end
    for (int j = 0; j < 6 && j < n; j++) begin
      vecs++; if (pi[j] !== 1 + 3 * j) begin errs++; $display("FAIL bp_spacing[%0d]: got %0d want %0d", j, pi[j], 1 + 3 * j); end
      vecs++; if (pp[j] !== 32'h1000 + 32'(j * 16)) begin errs++; $display("FAIL bp_order[%0d]: got %0h want %0h", j, pp[j], 32'h1000 + 32'(j * 16)); end
    end
    vecs++; if (idl[2] !== 1'b1) begin errs++; $display("FAIL bp_idle: got %b want 1", idl[2]); end
  endtask

  task automatic test_tl1();
    int n = 0;
    int pi [8];
    logic [31:0] pp [8];
    logic idle5 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v[0] = i < 4;
      if (i < 4) begin c = 1'b1; t = i[0]; pc = 32'h2000 + 32'(i * 4); tg = pc + 32'h80; end
      step();
      if (up[0] && n < 8) begin pi[n] = i; pp[n] = rpc[0]; n++; end
      if (i == 5) idle5 = idl[0];
    end
    v[0] = 1'b0;
    vecs++; if (n !== 4) begin errs++; $display("FAIL tl1_pulses: got %0d want 4", n); end
    for (int j = 0; j < 4 && j < n; j++) begin
      vecs++; if (pi[j] !== 1 + j || pp[j] !== 32'h2000 + 32'(j * 4)) begin errs++; $display("FAIL tl1_pulse[%0d]: got @%0d %0h want @%0d %0h", j, pi[j], pp[j], 1 + j, 32'h2000 + 32'(j * 4)); end
    end
    vecs++; if (idle5 !== 1'b1) begin errs++; $display("FAIL tl1_idle: got %b want 1", idle5); end
  endtask

  task automatic test_reset_mid();
    int strobes = 0;
    for (int i = 0; i < 5; i++) begin
      v[1] = 1'b1; c = 1'b1; t = 1'b1; pc = 32'h3000 + 32'(i * 16); tg = pc + 32'h8;
      step();
    end
    v[1] = 1'b0;
    vecs++; if (qc[1] !== 3'd3 || up[1] !== 1'b0) begin errs++; $display("FAIL mid_pre_state: got count %0d strobe %b want 3 0", qc[1], up[1]); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vecs++; if (qc[1] !== 3'd0 || idl[1] !== 1'b1) begin errs++; $display("FAIL mid_flush: got count %0d idle %b want 0 1", qc[1], idl[1]); end
    vecs++; if (rpc[1] !== 32'h0) begin errs++; $display("FAIL mid_pc_cleared: got %0h want 0", rpc[1]); end
    repeat (4) begin
      step();
      if (up[1] || ub[1]) strobes++;
    end
    vecs++; if (strobes !== 0) begin errs++; $display("FAIL mid_no_strobes: got %0d want 0", strobes); end
    c = 1'b0; t = 1'b1; pc = 32'h5000; tg = 32'h5100; v[1] = 1'b1;
    step();
    v[1] = 1'b0;
    vecs++; if (ub[1] !== 1'b0) begin errs++; $display("FAIL mid_new_early: got %b want 0", ub[1]); end
    step();
    vecs++; if ({up[1], ub[1], rpc[1]} !== {2'b01, 32'h5000}) begin errs++; $display("FAIL mid_new_issue: got %b%b %0h want 01 5000", up[1], ub[1], rpc[1]); end
    repeat (3) step();
  endtask

  initial begin
    rst = 1'b1; v = 3'b000; c = 1'b0; t = 1'b0; pc = '0; tg = '0;
    test_reset();
    test_single();
    test_filter();
    test_backpressure();
    test_tl1();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
